// File: rtl/alu_pkg.sv
// alu_pkg: op codes, op width and FSM state encoding shared by the serial ALU
package alu_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/full_adder1.sv
// full_adder1: single-bit full adder
// Ports: a, b, cin -> s (sum), cout (carry out)
module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/bit_serial_alu.sv
// bit_serial_alu: WIDTH-cycle LSB-first serial ALU (ADD/SUB/AND/OR/XOR) with valid/ready handshakes
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready, op, a, b accept an operation;
//        out_valid/out_ready retire result, carry_out, overflow, zero.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic ari, fa_b, fa_s, fa_cout, bit_r, last;

    assign ari  = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign fa_b = b_q[0] ^ (op_q == OP_SUB);
    assign last = cnt_q == CW'(WIDTH - 1);

    full_adder1 u_fa (
        .a    (a_q[0]),
        .b    (fa_b),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // reserved op codes fall through to a constant 0 bit
    assign bit_r = ari                ? fa_s :
                   (op_q == OP_AND)   ? a_q[0] & b_q[0] :
                   (op_q == OP_OR)    ? a_q[0] | b_q[0] :
                   (op_q == OP_XOR)   ? a_q[0] ^ b_q[0] : 1'b0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        if (state_q == S_IDLE && in_valid) begin
            a_d     = a;
            b_d     = b;
            op_d    = op;
            cnt_d   = '0;
            carry_d = (op == OP_SUB);
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            // operands shift right so bit 0 is always the bit under process
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            acc_d   = {bit_r, acc_q[WIDTH-1:1]};
            carry_d = ari ? fa_cout : 1'b0;
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                state_d     = S_DONE;
                result_d    = acc_d;
                carry_out_d = carry_d;
                // carry_q is the carry into the MSB at this point
                overflow_d  = ari & (carry_q ^ fa_cout);
                zero_d      = (acc_d == '0);
            end
        end else if (state_q == S_DONE && out_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_bit_serial_alu.sv
// tb_bit_serial_alu: directed-vector self-checking bench for bit_serial_alu
module tb_bit_serial_alu;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'b000;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       carry_out;
    logic       overflow;
    logic       zero;

    int n_tests = 0;
    int n_fail  = 0;

    bit_serial_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // accept one op, wait for DONE (bounded), optionally pulse in_valid during RUN
    // and stall out_ready, then check outputs and retirement
    task automatic run(input string tag, input logic [2:0] o, input logic [7:0] x,
                       input logic [7:0] y, input bit pulse, input int stall,
                       input logic [7:0] er, input logic ec, input logic ev, input logic ez);
        int n;
        @(negedge clk);
        chk({tag, "/in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk({tag, "/in_ready_run"}, in_ready, 0);
        n = 0;
        while (n < 20) begin
            if (pulse) begin
                in_valid = n[0]; op = OP_SUB; a = 8'hFF; b = 8'h00;
            end
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        chk({tag, "/latency"}, n, 8);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "/stall_valid"}, out_valid, 1);
            chk({tag, "/stall_in_ready"}, in_ready, 0);
            chk({tag, "/stall_result"}, result, er);
        end
        @(negedge clk);
        chk({tag, "/result"}, result, er);
        chk({tag, "/carry"}, carry_out, ec);
        chk({tag, "/overflow"}, overflow, ev);
        chk({tag, "/zero"}, zero, ez);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "/retire_valid"}, out_valid, 0);
        chk({tag, "/retire_in_ready"}, in_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst/in_ready", in_ready, 1);
        chk("rst/out_valid", out_valid, 0);
        chk("rst/result", result, 0);
        chk("rst/flags", {carry_out, overflow, zero}, 3'b000);
        rst_n = 1'b1;

        run("add_7f_01", OP_ADD, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0);
        run("sub_05_07", OP_SUB, 8'h05, 8'h07, 0, 0, 8'hFE, 0, 0, 0);
        run("add_ff_01", OP_ADD, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
        run("xor_a5_a5", OP_XOR, 8'hA5, 8'hA5, 0, 0, 8'h00, 0, 0, 1);
        run("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 0, 0, 8'h30, 0, 0, 0);
        run("or_0f_30",  OP_OR,  8'h0F, 8'h30, 0, 0, 8'h3F, 0, 0, 0);
        run("sub_80_01", OP_SUB, 8'h80, 8'h01, 0, 0, 8'h7F, 1, 1, 0);
        run("reserved",  3'b101, 8'hFF, 8'hFF, 0, 0, 8'h00, 0, 0, 1);
        run("stall_add", OP_ADD, 8'h10, 8'h20, 1, 5, 8'h30, 0, 0, 0);

        // reset while bit 3 is under process (4th edge after accept)
        @(negedge clk);
        in_valid = 1'b1; op = OP_ADD; a = 8'h55; b = 8'h0A;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst/in_ready", in_ready, 1);
        chk("midrst/out_valid", out_valid, 0);
        chk("midrst/result", result, 0);
        run("add_02_03", OP_ADD, 8'h02, 8'h03, 0, 0, 8'h05, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
